priv_1_12_clint: RTL and testbench

PRIV_1_12_CLINT -- requirements
Module: priv_1_12_clint

---
 rtl/priv_1_12_clint.sv | 150 +++++++++++++++
 tb/tb_priv_1_12_clint.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_1_12_clint.sv
// Machine-mode core-local interruptor: msip, mtime and mtimecmp registers plus a
// notifier that reports ext/soft/timer level changes as one set/clear pulse per cycle.
module priv_1_12_clint #(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [15:0] addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic        ext_irq,
    output logic        timer_int_m,
    output logic        soft_int_m,
    output logic        ext_int_m,
    output logic        clear_timer_int_m,
    output logic        clear_soft_int_m,
    output logic        clear_ext_int_m
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    localparam logic [15:0] A_MSIP   = 16'h0000;
    localparam logic [15:0] A_CMP_LO = 16'h4000;
    localparam logic [15:0] A_CMP_HI = 16'h4004;
    localparam logic [15:0] A_MT_LO  = 16'hBFF8;
    localparam logic [15:0] A_MT_HI  = 16'hBFFC;

    logic          r_ack;
    logic [31:0]   r_rdata;
    logic          r_msip;
    logic [63:0]   r_mtimecmp;
    logic [63:0]   r_mtime;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_sync;
    // per-source vectors are ordered {ext, soft, timer}
    logic [2:0]    r_rep;
    logic [2:0]    r_set;
    logic [2:0]    r_clr;

    logic          w_busy;
    logic          w_wr;
    logic          w_rd;
    logic          w_tick;
    logic [31:0]   w_rmux;
    logic [2:0]    w_lvl;
    logic [2:0]    w_pend;
    logic [2:0]    w_pick;

    assign w_busy = nRST & (ren | wen) & ~r_ack;
    assign w_wr   = w_busy & wen;
    assign w_rd   = w_busy & ren & ~wen;
    assign w_tick = (r_pre == PMAX);

    always_comb begin
        w_rmux = '0;
        case (addr)
            A_MSIP:   w_rmux = {31'd0, r_msip};
            A_CMP_LO: w_rmux = r_mtimecmp[31:0];
            A_CMP_HI: w_rmux = r_mtimecmp[63:32];
            A_MT_LO:  w_rmux = r_mtime[31:0];
            A_MT_HI:  w_rmux = r_mtime[63:32];
            default:  w_rmux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_busy;
            r_rdata <= w_rd ? w_rmux : '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= '1;
        end else if (w_wr) begin
            case (addr)
                A_MSIP:   r_msip             <= wdata[0];
                A_CMP_LO: r_mtimecmp[31:0]   <= wdata;
                A_CMP_HI: r_mtimecmp[63:32]  <= wdata;
                default:  ;
            endcase
        end
    end

    // a software write to either half suppresses that cycle's increment
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_wr && addr == A_MT_LO)
                r_mtime[31:0] <= wdata;
            else if (w_wr && addr == A_MT_HI)
                r_mtime[63:32] <= wdata;
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_sync <= '0;
        else
            r_sync <= {r_sync[0], ext_irq};
    end

    assign w_lvl  = {r_sync[1], r_msip, (r_mtime >= r_mtimecmp)};
    assign w_pend = w_lvl ^ r_rep;

    always_comb begin
        w_pick = 3'b000;
        if (w_pend[2])
            w_pick = 3'b100;
        else if (w_pend[1])
            w_pick = 3'b010;
        else if (w_pend[0])
            w_pick = 3'b001;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rep <= '0;
            r_set <= '0;
            r_clr <= '0;
        end else begin
            r_rep <= (r_rep & ~w_pick) | (w_lvl & w_pick);
            r_set <= w_pick & w_lvl;
            r_clr <= w_pick & ~w_lvl;
        end
    end

    assign rdata             = r_rdata;
    assign busy              = w_busy;
    assign ext_int_m         = r_set[2];
    assign soft_int_m        = r_set[1];
    assign timer_int_m       = r_set[0];
    assign clear_ext_int_m   = r_clr[2];
    assign clear_soft_int_m  = r_clr[1];
    assign clear_timer_int_m = r_clr[0];

endmodule

// File: tb/tb_priv_1_12_clint.sv
// Scoreboard bench for priv_1_12_clint: reads and interrupt pulses are queued
// as expectations and checked by a negedge monitor.
module tb_priv_1_12_clint;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [15:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic        ext_irq;

    logic [31:0] rdata, rdata4;
    logic        busy, busy4;
    logic        t_set, s_set, e_set, t_clr, s_clr, e_clr;
    logic        t_set4, s_set4, e_set4, t_clr4, s_clr4, e_clr4;

    localparam int TSET = 0, TCLR = 1, SSET = 2, SCLR = 3, ESET = 4, ECLR = 5;

    priv_1_12_clint #(.PRESCALE(1)) u_dut (
        .CLK(CLK), .nRST(nRST), .addr(addr), .ren(ren), .wen(wen),
        .wdata(wdata), .rdata(rdata), .busy(busy), .ext_irq(ext_irq),
        .timer_int_m(t_set), .soft_int_m(s_set), .ext_int_m(e_set),
        .clear_timer_int_m(t_clr), .clear_soft_int_m(s_clr),
        .clear_ext_int_m(e_clr)
    );

    priv_1_12_clint #(.PRESCALE(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .addr(addr), .ren(ren), .wen(wen),
        .wdata(wdata), .rdata(rdata4), .busy(busy4), .ext_irq(ext_irq),
        .timer_int_m(t_set4), .soft_int_m(s_set4), .ext_int_m(e_set4),
        .clear_timer_int_m(t_clr4), .clear_soft_int_m(s_clr4),
        .clear_ext_int_m(e_clr4)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
        bit          d4;
    } rd_t;

    typedef struct {
        string nm;
        int    code;
    } pl_t;

    rd_t rd_q[$];
    pl_t pl_q[$];
    int  p_cyc[6];

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void fail(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected DUT response", nm);
    endfunction

    task automatic do_req(input logic [15:0] a, input logic r, input logic w,
                          input logic [31:0] d, output int c);
        int n;
        addr  = a;
        ren   = r;
        wen   = w;
        wdata = d;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (busy && n < 8);
        c = cyc;
        check("req_done", busy, 0);
        ren = 0;
        wen = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic wrc(input logic [15:0] a, input logic [31:0] d, output int c);
        do_req(a, 1'b0, 1'b1, d, c);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        int c;
        do_req(a, 1'b0, 1'b1, d, c);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e,
                      input bit d4, input string nm);
        rd_t it;
        int  c;
        it.nm  = nm;
        it.exp = e;
        it.d4  = d4;
        rd_q.push_back(it);
        do_req(a, 1'b1, 1'b0, 32'd0, c);
    endtask

    task automatic expect_pulse(input string nm, input int code);
        pl_t p;
        p.nm   = nm;
        p.code = code;
        pl_q.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // monitor: bus responses and interrupt pulses
    bit   pbusy  = 0;
    bit   rdflag = 0;
    int   bcnt   = 0;
    always @(negedge CLK) begin
        rd_t        e;
        pl_t        p;
        logic [5:0] v;
        int         code;
        if (busy) begin
            bcnt++;
            rdflag = ren & ~wen;
        end else if (pbusy) begin
            check("busy_cycles", bcnt, 1);
            bcnt = 0;
            if (rdflag) begin
                if (rd_q.size() == 0) begin
                    fail("rd_unexpected");
                end else begin
                    e = rd_q.pop_front();
                    check(e.nm, e.d4 ? rdata4 : rdata, e.exp);
                end
            end else begin
                check("rdata_wr_resp", rdata, 0);
            end
        end else begin
            check("rdata_idle", rdata, 0);
        end
        pbusy = busy;

        v = {e_clr, e_set, s_clr, s_set, t_clr, t_set};
        if (v != 6'd0) begin
            check("pulse_onehot", $countones(v), 1);
            code = 0;
            for (int i = 5; i >= 0; i--)
                if (v[i]) code = i;
            p_cyc[code] = cyc;
            if (pl_q.size() == 0) begin
                fail("pulse_unexpected");
            end else begin
                p = pl_q.pop_front();
                check(p.nm, code, p.code);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cw;
        nRST    = 1'b0;
        addr    = '0;
        ren     = 1'b0;
        wen     = 1'b0;
        wdata   = '0;
        ext_irq = 1'b0;
        idle(3);
        check("rst_busy", {busy, busy4}, 0);
        check("rst_rdata", {rdata, rdata4}, 0);
        check("rst_pulses", {e_clr, e_set, s_clr, s_set, t_clr, t_set}, 0);
        nRST = 1'b1;
        idle(1);

        rd(16'h4000, 32'hFFFF_FFFF, 0, "cmp_lo_rst");
        rd(16'h4004, 32'hFFFF_FFFF, 0, "cmp_hi_rst");
        rd(16'h0000, 32'h0, 0, "msip_rst");

        rd(16'h0008, 32'h0, 0, "unmapped_0008");
        rd(16'h4002, 32'h0, 0, "misaligned_4002");
        wr(16'h4002, 32'h0);
        rd(16'h4000, 32'hFFFF_FFFF, 0, "cmp_lo_after_bad_wr");

        // PRESCALE=4: carry from lo into hi after exactly four cycles
        wr(16'hBFFC, 32'h1);
        wrc(16'hBFF8, 32'hFFFF_FFFF, cw);
        idle(3);
        rd(16'hBFF8, 32'h0, 1, "mt4_lo_carry");
        rd(16'hBFFC, 32'h2, 1, "mt4_hi_carry");

        // full 64-bit wrap; PRESCALE=1 copy briefly equals all-ones mtimecmp
        wr(16'hBFFC, 32'hFFFF_FFFF);
        expect_pulse("t_set_allones", TSET);
        expect_pulse("t_clr_wrap", TCLR);
        wrc(16'hBFF8, 32'hFFFF_FFFF, cw);
        idle(3);
        rd(16'hBFF8, 32'h0, 1, "mt4_lo_wrap");
        rd(16'hBFFC, 32'h0, 1, "mt4_hi_wrap");
        check("t_set_wrap_latency", p_cyc[TSET] - cw, 1);

        // timer compare at 0x10, then clear by raising mtimecmp
        wrc(16'hBFF8, 32'h0, c0);
        wr(16'h4000, 32'h10);
        expect_pulse("t_set_0x10", TSET);
        wr(16'h4004, 32'h0);
        idle(20);
        check("t_set_0x10_cycle", p_cyc[TSET] - c0, 17);
        expect_pulse("t_clr_0x100", TCLR);
        wrc(16'h4000, 32'h100, cw);
        wr(16'h4004, 32'hFFFF_FFFF);
        idle(4);
        check("t_clr_latency", p_cyc[TCLR] - cw, 1);
        rd(16'h4000, 32'h100, 0, "cmp_lo_rb");

        // ext and soft levels arrive together: ext first, soft next cycle
        ext_irq = 1'b1;
        idle(1);
        expect_pulse("e_set_prio", ESET);
        expect_pulse("s_set_after_ext", SSET);
        wr(16'h0000, 32'hFFFF_FFFF);
        idle(3);
        check("soft_after_ext_gap", p_cyc[SSET] - p_cyc[ESET], 1);
        rd(16'h0000, 32'h1, 0, "msip_bit0_only");
        expect_pulse("e_clr_level", ECLR);
        ext_irq = 1'b0;
        idle(5);
        expect_pulse("s_clr_level", SCLR);
        wr(16'h0000, 32'h0);
        idle(3);

        // one-cycle ext glitch while soft is being reported
        expect_pulse("s_set_glitch", SSET);
        expect_pulse("e_set_glitch", ESET);
        expect_pulse("e_clr_glitch", ECLR);
        fork
            wr(16'h0000, 32'h1);
            begin
                @(posedge CLK);
                #1;
                ext_irq = 1'b1;
                @(posedge CLK);
                #1;
                ext_irq = 1'b0;
            end
        join
        idle(6);
        expect_pulse("s_clr_glitch", SCLR);
        wr(16'h0000, 32'h0);
        idle(3);

        // reset in the middle of a mtimecmp hi write
        addr  = 16'h4004;
        wen   = 1'b1;
        wdata = 32'h0;
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_busy", {busy, busy4}, 0);
        check("midrst_rdata", {rdata, rdata4}, 0);
        check("midrst_pulses", {e_clr, e_set, s_clr, s_set, t_clr, t_set}, 0);
        wen = 1'b0;
        idle(2);
        nRST = 1'b1;
        idle(1);
        rd(16'h4004, 32'hFFFF_FFFF, 0, "cmp_hi_after_rst");
        rd(16'h4000, 32'hFFFF_FFFF, 0, "cmp_lo_after_rst");
        rd(16'hBFFC, 32'h0, 0, "mt_hi_after_rst");
        rd(16'h0000, 32'h0, 0, "msip_after_rst");
        idle(20);

        check("rd_q_empty", rd_q.size(), 0);
        check("pulse_q_empty", pl_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
